// File: rtl/wb_wen_queue_pkg.sv
// Shared constants and the write-back request type for the register-file write-back queue.
package wb_wen_queue_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_wen_queue_onehot_decode.sv
// Address-to-one-hot decoder with enable; addresses at or above N decode to all zeros.
module onehot_decode #(
  parameter int N  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic [AW-1:0] addr,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (addr == AW'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_wen_queue.sv
// Write-back staging FIFO feeding a registered one-hot register-file write enable.
// Optional forwarding ports are enabled by defining WB_WEN_QUEUE_BYPASS_EN.
module wb_wen_queue
  import wb_wen_queue_pkg::*;
#(
  parameter int NREGS    = wb_wen_queue_pkg::NREGS,
  parameter int XLEN     = wb_wen_queue_pkg::XLEN,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic [XLEN-1:0]  req_data,
  input  logic             drain_en,
`ifdef WB_WEN_QUEUE_BYPASS_EN
  input  logic [AW-1:0]    byp_addr,
  output logic             byp_hit,
  output logic [XLEN-1:0]  byp_data,
`endif
  output logic [NREGS-1:0] wen,
  output logic [XLEN-1:0]  wdata,
  output logic [NREGS-1:0] pending,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [XLEN-1:0]  ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [NREGS-1:0] ent_oh   [DEPTH];

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             accept;
  logic             addr_ok;
  logic             push;
  logic             pop;
  logic [NREGS-1:0] wen_nxt;
  logic [XLEN-1:0]  wdata_nxt;
  logic [NREGS-1:0] wen_p1;
  logic [XLEN-1:0]  wdata_p1;
  logic             vld_p1;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign req_ready = !full && !rst;

  // Dropped requests (hardwired zero register, out-of-range address) still handshake.
  assign addr_ok = (int'(req_addr) < NREGS) && !((ZERO_REG != 0) && (req_addr == '0));
  assign accept  = req_valid && req_ready;
  assign push    = accept && addr_ok;
  assign pop     = drain_en && !empty && !rst;

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= req_addr;
      ent_data[wr_ptr] <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + PW'(1);
        ent_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + PW'(1);
        ent_vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pend
    onehot_decode #(.N(NREGS), .AW(AW)) u_dec (
      .addr   (ent_addr[g]),
      .en     (ent_vld[g]),
      .onehot (ent_oh[g])
    );
  end

  always_comb begin
    pending = '0;
    for (int g = 0; g < DEPTH; g++) pending |= ent_oh[g];
    if (ZERO_REG != 0) pending[0] = 1'b0;
  end

  onehot_decode #(.N(NREGS), .AW(AW)) u_wen_dec (
    .addr   (ent_addr[rd_ptr]),
    .en     (pop),
    .onehot (wen_nxt)
  );

  assign wdata_nxt = pop ? ent_data[rd_ptr] : '0;

  // Stage p1: registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_p1   <= '0;
      wdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      wen_p1   <= wen_nxt;
      wdata_p1 <= wdata_nxt;
      vld_p1   <= pop;
    end
  end

  assign wen   = wen_p1;
  assign wdata = wdata_p1;

`ifdef WB_WEN_QUEUE_BYPASS_EN
  logic [PW-1:0] byp_idx;

  // Output stage first, then queue entries oldest to youngest so the youngest wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = '0;
    if (int'(byp_addr) < NREGS) begin
      if (vld_p1 && wen_p1[byp_addr]) begin
        byp_hit  = 1'b1;
        byp_data = wdata_p1;
      end
      for (int k = 0; k < DEPTH; k++) begin
        byp_idx = PW'(int'(rd_ptr) + k);
        if ((k < int'(count)) && (ent_addr[byp_idx] == byp_addr)) begin
          byp_hit  = 1'b1;
          byp_data = ent_data[byp_idx];
        end
      end
    end
    if ((ZERO_REG != 0) && (byp_addr == '0)) begin
      byp_hit  = 1'b0;
      byp_data = '0;
    end
  end
`endif

endmodule
